// File: rtl/mem_lsu.sv
// Load/store unit: one request at a time, IDLE -> ACCESS -> RESP; 2-cycle latency legal, 1-cycle error.
// req_ready only in IDLE; the response is held until resp_ready, so nothing new is accepted until then.
module mem_lsu #(
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_raddr_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [7:0]  mem_wmask_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        wen_q, uns_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;

  logic        req_legal;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] rd_shift, ld_ext, word_addr;

  always_comb begin
    req_legal = (req_size_i != 2'd3);
    if (ALIGN_CHECK != 0) begin
      if (req_size_i == 2'd1 && req_addr_i[0]) req_legal = 1'b0;
      if (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00) req_legal = 1'b0;
    end
  end

  // Without alignment checking, half/word low address bits are simply dropped.
  always_comb begin
    off  = 2'd0;
    mask = 4'b1111;
    case (size_q)
      2'd0: begin off = addr_q[1:0];         mask = 4'b0001 << addr_q[1:0]; end
      2'd1: begin off = {addr_q[1], 1'b0};   mask = 4'b0011 << {addr_q[1], 1'b0}; end
      default: begin off = 2'd0;             mask = 4'b1111; end
    endcase
  end

  always_comb begin
    rd_shift = mem_rdata_i >> {off, 3'b000};
    case (size_q)
      2'd0:    ld_ext = uns_q ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    ld_ext = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_valid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = req_legal ? ACCESS : RESP;
      end
      ACCESS: begin
        mem_valid_o = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      size_q  <= 2'd0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          wen_q   <= req_wen_i;
          uns_q   <= req_unsigned_i;
          addr_q  <= req_addr_i;
          wdata_q <= req_wdata_i;
          size_q  <= req_size_i;
          err_q   <= !req_legal;
          rdata_q <= 32'd0;
        end
        ACCESS: rdata_q <= wen_q ? 32'd0 : ld_ext;
        RESP: if (resp_ready_i) begin
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign word_addr    = {addr_q[31:2], 2'b00};
  assign mem_raddr_o  = mem_valid_o ? word_addr : 32'd0;
  assign mem_waddr_o  = mem_valid_o ? word_addr : 32'd0;
  assign mem_wen_o    = mem_valid_o & wen_q;
  assign mem_wdata_o  = mem_valid_o ? (wdata_q << {off, 3'b000}) : 32'd0;
  assign mem_wmask_o  = {4'b0000, (mem_valid_o && wen_q) ? mask : 4'b0000};
  assign resp_rdata_o = resp_valid_o ? rdata_q : 32'd0;
  assign resp_err_o   = resp_valid_o & err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: inputs driven and outputs checked on the falling clock edge.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_assert = 0;
  int n_fail   = 0;
  int mv_cnt   = 0;
  int mv_base  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_valid === 1'b1) mv_cnt++;

  mem_lsu #(.ALIGN_CHECK(1)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_valid_o(mem_valid), .mem_raddr_o(mem_raddr), .mem_wen_o(mem_wen),
    .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; returns on the next falling edge.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5; req_size = 2'd0; req_wen = ~wen;
    req_unsigned = ~uns;
  endtask

  task automatic release_resp;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0000;
    req_wdata = 32'd0; req_size = 2'd2; req_unsigned = 1'b0; resp_ready = 1'b0;
    mem_rdata = 32'd0;

    // Reset, with a request pending that must not be taken
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_wmask", {24'd0, mem_wmask}, 32'd0);
    chk("rst_mem_raddr", mem_raddr, 32'd0);
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", mv_cnt, 32'd0);

    // Word load
    mem_rdata = 32'hDEAD_BEEF;
    mv_base = mv_cnt;
    issue(1'b0, 32'h8000_0004, 32'd0, 2'd2, 1'b0);
    chk("wl_mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("wl_mem_raddr", mem_raddr, 32'h8000_0004);
    chk("wl_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("wl_req_ready", {31'd0, req_ready}, 32'd0);
    chk("wl_resp_early", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("wl_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("wl_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("wl_err", {31'd0, resp_err}, 32'd0);
    chk("wl_mem_valid_off", {31'd0, mem_valid}, 32'd0);
    chk("wl_mv_once", mv_cnt - mv_base, 32'd1);
    release_resp();

    // Byte load at lane 3, signed then unsigned
    mem_rdata = 32'h80FF_FFFF;
    issue(1'b0, 32'h8000_0003, 32'd0, 2'd0, 1'b0);
    chk("bls_raddr", mem_raddr, 32'h8000_0000);
    @(negedge clk);
    chk("bls_rdata", resp_rdata, 32'hFFFF_FF80);
    release_resp();
    issue(1'b0, 32'h8000_0003, 32'd0, 2'd0, 1'b1);
    @(negedge clk);
    chk("blu_rdata", resp_rdata, 32'h0000_0080);
    release_resp();

    // Half load at upper half, signed
    mem_rdata = 32'h8001_7777;
    issue(1'b0, 32'h8000_0002, 32'd0, 2'd1, 1'b0);
    @(negedge clk);
    chk("hls_rdata", resp_rdata, 32'hFFFF_8001);
    release_resp();

    // Half store at upper half; read data must be discarded
    mem_rdata = 32'h5555_5555;
    issue(1'b1, 32'h8000_0002, 32'h0000_1234, 2'd1, 1'b0);
    chk("hs_wen", {31'd0, mem_wen}, 32'd1);
    chk("hs_waddr", mem_waddr, 32'h8000_0000);
    chk("hs_raddr", mem_raddr, 32'h8000_0000);
    chk("hs_wmask", {24'd0, mem_wmask}, 32'h0000_000C);
    chk("hs_wdata_hi", {16'd0, mem_wdata[31:16]}, 32'h0000_1234);
    @(negedge clk);
    chk("hs_rdata", resp_rdata, 32'd0);
    chk("hs_err", {31'd0, resp_err}, 32'd0);
    release_resp();

    // Byte store at lane 1
    issue(1'b1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 1'b0);
    chk("bs_wmask", {24'd0, mem_wmask}, 32'h0000_0002);
    chk("bs_wdata", mem_wdata, 32'h0000_AB00);
    @(negedge clk);
    release_resp();

    // Misaligned word and reserved size: error next cycle, no memory strobe
    mv_base = mv_cnt;
    issue(1'b0, 32'h8000_0001, 32'd0, 2'd2, 1'b0);
    chk("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("mis_err", {31'd0, resp_err}, 32'd1);
    chk("mis_rdata", resp_rdata, 32'd0);
    chk("mis_mem_valid", {31'd0, mem_valid}, 32'd0);
    release_resp();
    issue(1'b0, 32'h8000_0000, 32'd0, 2'd3, 1'b0);
    chk("rsv_err", {31'd0, resp_err}, 32'd1);
    chk("rsv_resp_valid", {31'd0, resp_valid}, 32'd1);
    release_resp();
    chk("err_no_mem", mv_cnt - mv_base, 32'd0);

    // Backpressure: response held, new requests ignored
    mem_rdata = 32'h1122_3344;
    issue(1'b0, 32'h8000_0008, 32'd0, 2'd2, 1'b0);
    @(negedge clk);
    mv_base = mv_cnt;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010; req_size = 2'd2;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, 32'h1122_3344);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    release_resp();
    chk("bp_no_mem", mv_cnt - mv_base, 32'd0);

    // Reset during ACCESS aborts with no retry and no response
    mv_base = mv_cnt;
    issue(1'b0, 32'h8000_0004, 32'd0, 2'd2, 1'b0);
    chk("ra_in_access", {31'd0, mem_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("ra_req_ready", {31'd0, req_ready}, 32'd1);
    chk("ra_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("ra_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("ra_rdata", resp_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ra_quiet", {30'd0, resp_valid, mem_valid}, 32'd0);
    end
    chk("ra_no_retry", mv_cnt - mv_base, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: ALIGN_CHECK, default 1, 1 = misaligned half/word accesses return an error; 0 = address low bits ignored for half/word (forced aligned).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, LSB-justified.
REQ-009 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  core consumes response.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or reserved-size request.
REQ-015 mem_valid  output  1  memory access strobe to memory responder.
REQ-016 mem_raddr  output  32  word-aligned read address.
REQ-017 mem_wen  output  1  write enable, only with mem_valid.
REQ-018 mem_waddr  output  32  word-aligned write address.
REQ-019 mem_wdata  output  32  lane-shifted store data.
REQ-020 mem_wmask  output  8  byte-lane mask, bits [7:4] always 0.
REQ-021 mem_rdata  input  32  word returned by memory in the same cycle mem_valid is high.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-023 IDLE: on req_valid, latch wen/addr/wdata/size/unsigned; go to ACCESS if legal, else RESP with error.
REQ-024 Legal: size != 3, and if ALIGN_CHECK=1, half needs addr[0]=0, word needs addr[1:0]=0.
REQ-025 ACCESS lasts exactly one cycle: mem_valid=1, mem_raddr=mem_waddr={addr[31:2],2'b00}, mem_wen=latched wen; then RESP.
REQ-026 Outside ACCESS: mem_valid=0, mem_wen=0, mem_wmask=0, addresses/wdata 0.
REQ-027 Store mask: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111; off = addr[1:0] (half off in {0,2}).
REQ-028 mem_wdata = wdata << (8*off); unused lanes don't-care but driven deterministically (shift result).
REQ-029 Loads: at end of ACCESS register mem_rdata >> (8*off), truncate to size, sign- or zero-extend to 32 bits.
REQ-030 Stores also drive mem_raddr (responder reads unconditionally); read data discarded, resp_rdata = 0.
REQ-031 RESP: resp_valid=1, resp_rdata/resp_err stable until resp_ready; on resp_ready go IDLE.
REQ-032 Request-to-response latency: 2 cycles legal, 1 cycle error; throughput max one request per 3 cycles (no back-to-back acceptance while RESP).
REQ-033 Error requests never assert mem_valid.
REQ-034 req_* inputs ignored outside IDLE; changes after acceptance do not affect the transaction.

Reset
REQ-035 reset high at a clock edge: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, all mem_* outputs 0.
REQ-036 reset during ACCESS or RESP aborts transaction; no response is produced; an in-flight ACCESS cycle sampled with reset does not retry.
REQ-037 req_valid during reset cycle is not accepted.

Verification
REQ-038 Word load addr 0x80000004, mem_rdata 0xDEADBEEF -> one mem_valid cycle, mem_raddr 0x80000004, resp_rdata 0xDEADBEEF, resp_err 0, resp_valid two cycles after accept.
REQ-039 Byte load signed addr 0x80000003, mem_rdata 0x80FFFFFF -> resp_rdata 0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
REQ-040 Half store addr 0x80000002 wdata 0x00001234 -> mem_wen 1, mem_waddr 0x80000000, mem_wmask 0x0C, mem_wdata[31:16] 0x1234, resp_rdata 0.
REQ-041 Word load addr 0x80000001 (ALIGN_CHECK=1) and size=3 -> no mem_valid, resp_err 1 next cycle, resp_rdata 0.
REQ-042 resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready 0, new req_valid ignored; release -> IDLE next cycle.
REQ-043 Reset asserted in ACCESS -> next cycle all outputs at reset values, no resp_valid afterward until new request.
